vga_sig_gen: RTL
================

VGA_SIG_GEN -- requirements
Module: vga_sig_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
REQ-002 Parameter H_VIS, default 640, SHALL set the visible pixels per line.
REQ-003 Parameter H_FP, default 16, SHALL set the horizontal front porch in pixels.
REQ-004 Parameter H_SP, default 96, SHALL set the horizontal sync width in pixels.
REQ-005 Parameter H_BP, default 48, SHALL set the horizontal back porch in pixels.
REQ-006 Parameter V_VIS, default 480, SHALL set the visible lines per frame.
REQ-007 Parameter V_FP, default 10, SHALL set the vertical front porch in lines.
REQ-008 Parameter V_SP, default 2, SHALL set the vertical sync width in lines.
REQ-009 Parameter V_BP, default 33, SHALL set the vertical back porch in lines.
REQ-010 CLK  input  1  SHALL be the 100 MHz system clock.
REQ-011 RESET_N  input  1  SHALL be the asynchronous active-low reset.
REQ-012 COLOUR_IN  input  12  SHALL carry the pixel colour from the pattern stage for the current ADDRESS_X/ADDRESS_Y.
REQ-013 ADDRESS_X  output  10  SHALL carry the horizontal pixel counter.
REQ-014 ADDRESS_Y  output  9  SHALL carry the vertical line address.
REQ-015 VGA_HS  output  1  SHALL be the horizontal sync, active low.
REQ-016 VGA_VS  output  1  SHALL be the vertical sync, active low.
REQ-017 VGA_COLOUR  output  12  SHALL carry the RGB444 pixel to the DAC.
REQ-018 FRAME_START  output  1  SHALL be a one-CLK pulse at the start of each frame.

Function
REQ-019 A free-running 2-bit divider SHALL produce PIX_EN, high for one CLK in every 4 CLKs (25 MHz pixel rate), asserted when the divider equals 3.
REQ-020 The horizontal counter HC (0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SP+H_BP = 800) SHALL advance only on PIX_EN and wrap from 799 to 0.
REQ-021 The vertical counter VC (0..V_TOT-1, where V_TOT = 525) SHALL increment on PIX_EN when HC wraps, and wrap from 524 to 0 when HC also wraps.
REQ-022 ADDRESS_X SHALL equal HC.
REQ-023 ADDRESS_Y SHALL equal VC[8:0] while VC < V_VIS, and SHALL be held at 480 while VC >= V_VIS.
REQ-024 The sync, blank and colour outputs SHALL be registered on PIX_EN, one pixel (4 CLK) behind the counters, so that COLOUR_IN has 3 CLKs to settle.
REQ-025 The delayed horizontal sync SHALL be low exactly while the delayed HC is in 656..751.
REQ-026 The delayed vertical sync SHALL be low exactly while the delayed VC is in 490..491.
REQ-027 VGA_COLOUR SHALL be the registered COLOUR_IN when the delayed HC < H_VIS and the delayed VC < V_VIS, and 12'h000 otherwise.
REQ-028 FRAME_START SHALL pulse for one CLK on the PIX_EN cycle where HC and VC both wrap to 0.
REQ-029 Simultaneous HC and VC wrap SHALL produce HC = 0 and VC = 0 on the same PIX_EN cycle, with no skipped or duplicated line.

Reset
REQ-030 While RESET_N = 0 the divider, HC and VC SHALL be 0, ADDRESS_X SHALL be 0, and ADDRESS_Y SHALL be 0.
REQ-031 While RESET_N = 0, VGA_HS and VGA_VS SHALL be 1, VGA_COLOUR SHALL be 12'h000, and FRAME_START SHALL be 0.
REQ-032 Reset assertion mid-line SHALL force the reset values immediately, independent of CLK.
REQ-033 After RESET_N is released, the first PIX_EN SHALL occur on the 4th CLK edge.

Configuration
REQ-034 When macro VGA_SIG_GEN_BORDER_EN is defined, visible pixels with HC in {0, 639} or VC in {0, 479} SHALL output 12'hFFF, overriding COLOUR_IN.
REQ-035 When VGA_SIG_GEN_BORDER_EN is undefined, the border logic SHALL be absent and REQ-027 SHALL apply unmodified.

Verification
REQ-036 Release reset, run 1 frame -> exactly 800*525*4 = 1,680,000 CLKs between consecutive FRAME_START pulses.
REQ-037 Count over one line -> VGA_HS low for 384 CLKs, low edge 656 pixels after the delayed HC = 0.
REQ-038 Count over one frame -> VGA_VS low for 2 lines (6400 CLKs); ADDRESS_Y reads 480 throughout VC 480..524.
REQ-039 Drive COLOUR_IN = 12'hA5C constant -> VGA_COLOUR = 12'hA5C for pixel (10, 10), and 12'h000 at delayed HC = 700 or delayed VC = 500.
REQ-040 Assert RESET_N = 0 at HC = 300, VC = 200 -> all outputs at reset values within the same CLK; after release, FRAME_START after 1,680,000 CLKs.
REQ-041 With VGA_SIG_GEN_BORDER_EN defined and COLOUR_IN = 12'h000 -> pixels (0, 5), (639, 5), (5, 0) and (5, 479) output 12'hFFF, and pixel (5, 5) outputs 12'h000.

Source files
------------

// File: rtl/vga_sig_gen_if.sv
// Pixel bus between the VGA timing generator and the pattern stage / DAC.
// The master side is the generator; the slave side supplies colour and consumes timing.
interface vga_sig_gen_if;
  logic [11:0] colour_in;
  logic [9:0]  address_x;
  logic [8:0]  address_y;
  logic        vga_hs;
  logic        vga_vs;
  logic [11:0] vga_colour;
  logic        frame_start;

  modport master (
    input  colour_in,
    output address_x, address_y, vga_hs, vga_vs, vga_colour, frame_start
  );

  modport slave (
    output colour_in,
    input  address_x, address_y, vga_hs, vga_vs, vga_colour, frame_start
  );
endinterface

// File: rtl/vga_sig_gen.sv
// VGA timing generator: 25 MHz pixel enable from a 100 MHz clock, sync/blank/colour pipeline.
// Optional macro VGA_SIG_GEN_BORDER_EN paints a one-pixel white frame around the visible area.
module vga_sig_gen #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SP  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SP  = 2,
  parameter int V_BP  = 33
) (
  input logic           clk,
  input logic           reset_n,
  vga_sig_gen_if.master bus
);
  localparam int H_TOT = H_VIS + H_FP + H_SP + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SP + V_BP;

  localparam logic [9:0] HC_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] VC_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SP - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SP - 1);
  localparam logic [9:0] H_LIMIT  = 10'(H_VIS);
  localparam logic [9:0] V_LIMIT  = 10'(V_VIS);
  localparam logic [8:0] Y_HOLD   = 9'(V_VIS);

  logic [1:0]  div;
  logic        pix_en;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        hc_wrap;
  logic        vc_wrap;
  logic        visible;
  logic        hs_active;
  logic        vs_active;
  logic [11:0] pixel;
  logic        hs_q;
  logic        vs_q;
  logic [11:0] colour_q;
  logic        frame_start_q;

  assign pix_en  = (div == 2'd3);
  assign hc_wrap = (hc == HC_LAST);
  assign vc_wrap = (vc == VC_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= 2'd0;
      hc  <= 10'd0;
      vc  <= 10'd0;
    end else begin
      div <= div + 2'd1;
      if (pix_en) begin
        if (hc_wrap) begin
          hc <= 10'd0;
          vc <= vc_wrap ? 10'd0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  always_comb begin
    visible   = (hc < H_LIMIT) && (vc < V_LIMIT);
    hs_active = (hc >= HS_FIRST) && (hc <= HS_LAST);
    vs_active = (vc >= VS_FIRST) && (vc <= VS_LAST);
    // NOTE: pixel is given a default before any condition so no latch is inferred.
    pixel = 12'h000;
    if (visible) begin
      pixel = bus.colour_in;
    end
`ifdef VGA_SIG_GEN_BORDER_EN
    if (visible && (hc == 10'd0 || hc == H_LIMIT - 10'd1 ||
                    vc == 10'd0 || vc == V_LIMIT - 10'd1)) begin
      pixel = 12'hFFF;
    end
`endif
  end

  // Outputs trail the counters by one pixel; colour_in is sampled at the end of its pixel slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      colour_q      <= 12'h000;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en && hc_wrap && vc_wrap;
      if (pix_en) begin
        hs_q     <= !hs_active;
        vs_q     <= !vs_active;
        colour_q <= pixel;
      end
    end
  end

  assign bus.address_x   = hc;
  assign bus.address_y   = (vc < V_LIMIT) ? vc[8:0] : Y_HOLD;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_colour  = colour_q;
  assign bus.frame_start = frame_start_q;
endmodule
